ffu_fpop_sched: RTL and testbench
=================================

// Module: ffu_fpop_sched
// PURPOSE
//  Schedules FPop requests from the NTHR hardware threads of one core onto the single
//  FFU->LSU FPU request port. One request per thread is buffered. The port is shared by
//  round-robin arbitration and held until the LSU acks. Each in-flight op is matched to its
//  CPX FPU return by thread id, and per-thread done/busy status goes back to the FFU control.
// PARAMETERS
//  NTHR      4    number of threads (power of 2)
//  TIDW      2    thread id width, $clog2(NTHR)
//  DW        80   FPop request payload width (opcode + operands)
//  TO_CYC    1024 watchdog limit in cycles (used only with FFU_SCHED_TIMEOUT_EN)
// PORTS
//  rclk            in   1        core clock
//  reset           in   1        synchronous, active-high reset
//  thr_req_vld     in   NTHR     thread t offers a request
//  thr_req_data    in   NTHR*DW  payloads, thread t at [t*DW +: DW]
//  thr_req_rdy     out  NTHR     comb: thread t slot free (= ~thr_busy[t])
//  thr_kill        in   NTHR     flush: drop thread t's request if not yet granted
//  ffu_lsu_fpop_rq_vld out 1     request to LSU valid
//  ffu_lsu_data    out  DW       request payload
//  ffu_lsu_tid     out  TIDW     request thread id
//  lsu_ffu_ack     in   1        LSU accepts request (only meaningful while rq_vld)
//  cpx_fpu_vld     in   1        FPU result return valid
//  cpx_fpu_tid     in   TIDW     thread id of return
//  thr_busy        out  NTHR     slot state != FREE
//  thr_done        out  NTHR     1-cycle pulse, cycle after the matching return
//  sched_err       out  1        sticky: return to a thread that is not ISSUED
//  sched_timeout   out  1        sticky watchdog flag (0 when macro absent)
// BEHAVIOUR
//  Per-thread slot FSM: FREE -> PEND (vld&rdy, payload captured) -> GRANT (arb win)
//   -> ISSUED (ack) -> FREE (cpx return with matching tid).
//  thr_kill[t]: PEND->FREE at the next edge. Ignored in GRANT and ISSUED: a granted request
//   is never retracted, and its result still pulses thr_done.
//  Port FSM: IDLE/REQ. In IDLE with any PEND slot, the RR arbiter picks the first PEND slot at
//   or after ptr. The port enters REQ next edge; rq_vld/data/tid are registered and stable
//   until ack. On ack: slot->ISSUED, ptr=winner+1 (mod NTHR), port->IDLE. No regrant in the
//   ack cycle, so back-to-back requests are spaced by 1 idle cycle.
//  Latency: request accepted in cycle 0 -> PEND in cycle 1 -> rq_vld high from cycle 2.
//  Return in same cycle as a new thr_req_vld for that thread: not accepted (busy still 1).
//   Accepted the following cycle.
//  Return in same cycle as ack of another thread: both processed independently.
//  Return for a thread not ISSUED: ignored, sched_err set; cleared only by reset.
//  Reset values: all slots FREE, port IDLE, ptr=0, rq_vld=0, data=0, tid=0, thr_done=0,
//   thr_busy=0, sched_err=0, sched_timeout=0. Reset mid-operation abandons in-flight ops.
//   Returns arriving after reset set sched_err.
// CONFIGURATION
//  `FFU_SCHED_TIMEOUT_EN defined: per-thread counter (width $clog2(TO_CYC+1)) runs while the
//   slot is ISSUED and clears on leaving ISSUED. On reaching TO_CYC: sched_timeout set
//   (sticky) and the slot is forced to FREE with no thr_done pulse.
//  Macro undefined: no counters, sched_timeout tied to 0, ISSUED waits forever.
// STRUCTURE
//  ffu_sched_pkg: slot state enum {FREE,PEND,GRANT,ISSUED}, port state enum {IDLE,REQ},
//   NTHR/TIDW defaults.
//  Sub-module ffu_rr_arb: NTHR-way round-robin; inputs req vector + ptr, output one-hot
//   grant + encoded tid. Pure combinational; the pointer register lives in the parent.
// TESTING
//  1 single: thr0 req D=0xA5 cyc0 -> rq_vld cyc2, tid=0, data=0xA5; ack cyc4 -> rq_vld=0 cyc5;
//    cpx tid0 cyc10 -> thr_done[0] cyc11, thr_busy[0]=0 cyc11.
//  2 fairness: thr0..3 req together, ack every REQ cycle -> issue order 0,1,2,3. Then thr0,thr2
//    re-req with ptr=0 -> 0 then 2.
//  3 kill: thr1 PEND killed before grant -> never issued, busy[1]=0 next cycle. Kill during GRANT
//    -> still issued, done pulses.
//  4 errors: cpx tid3 while thread 3 FREE -> sched_err=1, no done, holds until reset. Reset while
//    REQ -> rq_vld=0 and all busy=0 next cycle.
//  5 collision: cpx tid2 and thr_req_vld[2] same cycle -> req refused (rdy=0), accepted next cycle.
//  6 timeout (macro on, TO_CYC=16): no return for 16 cycles -> sched_timeout=1, busy clears,
//    no done pulse. Macro off: busy stays 1.

Source files
------------

// File: rtl/ffu_sched_pkg.sv
// ffu_sched_pkg: slot/port state encodings and default sizing for the FPop scheduler
package ffu_sched_pkg;
  localparam int NTHR_DEF = 4;
  localparam int TIDW_DEF = $clog2(NTHR_DEF);
  typedef enum logic [1:0] {FREE, PEND, GRANT, ISSUED} slot_e;
  typedef enum logic {IDLE, REQ} port_e;
endpackage

// File: rtl/ffu_rr_arb.sv
// ffu_rr_arb: combinational round-robin pick of the first requester at or after ptr_i
module ffu_rr_arb #(
  parameter int NTHR = 4,
  parameter int TIDW = 2
) (
  input  logic [NTHR-1:0] req_i,
  input  logic [TIDW-1:0] ptr_i,
  output logic [NTHR-1:0] gnt_o,
  output logic [TIDW-1:0] tid_o
);
  logic [TIDW-1:0] idx;
  always_comb begin
    tid_o = '0;
    idx = '0;
    for (int i = NTHR - 1; i >= 0; i--) begin
      idx = ptr_i + TIDW'(i);
      tid_o = req_i[idx] ? idx : tid_o;
    end
    gnt_o = req_i[tid_o] ? NTHR'(1) << tid_o : '0;
  end
endmodule

// File: rtl/ffu_fpop_sched.sv
// ffu_fpop_sched: RR scheduler of per-thread FPops onto one LSU port; `FFU_SCHED_TIMEOUT_EN adds a per-thread watchdog
module ffu_fpop_sched
  import ffu_sched_pkg::*;
#(
  parameter int NTHR   = NTHR_DEF,
  parameter int TIDW   = TIDW_DEF,
  parameter int DW     = 80,
  parameter int TO_CYC = 1024
) (
  input  logic               rclk,
  input  logic               reset,
  input  logic [NTHR-1:0]    thr_req_vld,
  input  logic [NTHR*DW-1:0] thr_req_data,
  output logic [NTHR-1:0]    thr_req_rdy,
  input  logic [NTHR-1:0]    thr_kill,
  output logic               ffu_lsu_fpop_rq_vld,
  output logic [DW-1:0]      ffu_lsu_data,
  output logic [TIDW-1:0]    ffu_lsu_tid,
  input  logic               lsu_ffu_ack,
  input  logic               cpx_fpu_vld,
  input  logic [TIDW-1:0]    cpx_fpu_tid,
  output logic [NTHR-1:0]    thr_busy,
  output logic [NTHR-1:0]    thr_done,
  output logic               sched_err,
  output logic               sched_timeout
);
  slot_e [NTHR-1:0] slot_q, slot_d;
  logic [NTHR-1:0][DW-1:0] data_q, data_d;
  port_e port_q, port_d;
  logic [TIDW-1:0] ptr_q, ptr_d, tid_q, tid_d, arb_tid;
  logic [DW-1:0] rq_q, rq_d;
  logic [NTHR-1:0] done_q, done_d, arb_req, arb_gnt;
  logic err_q, err_d;
  ffu_rr_arb #(.NTHR(NTHR), .TIDW(TIDW)) u_arb (
    .req_i(arb_req),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .tid_o(arb_tid)
  );
`ifdef FFU_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [NTHR-1:0][CW-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  always_ff @(posedge rclk) begin
    if (reset) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  assign sched_timeout = to_q;
`else
  assign sched_timeout = TO_CYC < 0;
`endif
  always_comb begin
    for (int t = 0; t < NTHR; t++) begin
      thr_busy[t] = slot_q[t] != FREE;
      arb_req[t] = slot_q[t] == PEND && !thr_kill[t];
    end
  end
  always_comb begin
    slot_d = slot_q;
    data_d = data_q;
    port_d = port_q;
    ptr_d = ptr_q;
    tid_d = tid_q;
    rq_d = rq_q;
    done_d = '0;
    err_d = err_q;
    for (int t = 0; t < NTHR; t++) begin
      if (slot_q[t] == FREE && thr_req_vld[t]) begin
        slot_d[t] = PEND;
        data_d[t] = thr_req_data[t*DW +: DW];
      end
      if (slot_q[t] == PEND && thr_kill[t]) slot_d[t] = FREE;
    end
    if (port_q == IDLE && |arb_gnt) begin
      port_d = REQ;
      slot_d[arb_tid] = GRANT;
      tid_d = arb_tid;
      rq_d = data_q[arb_tid];
    end
    if (port_q == REQ && lsu_ffu_ack) begin
      port_d = IDLE;
      slot_d[tid_q] = ISSUED;
      ptr_d = tid_q + TIDW'(1);
    end
`ifdef FFU_SCHED_TIMEOUT_EN
    to_d = to_q;
    for (int t = 0; t < NTHR; t++) begin
      cnt_d[t] = slot_q[t] == ISSUED ? cnt_q[t] + CW'(1) : '0;
      if (slot_q[t] == ISSUED && cnt_q[t] == CW'(TO_CYC)) begin
        slot_d[t] = FREE;
        to_d = 1'b1;
      end
    end
`endif
    // a genuine return wins over a same-cycle watchdog expiry
    if (cpx_fpu_vld && slot_q[cpx_fpu_tid] == ISSUED) begin
      slot_d[cpx_fpu_tid] = FREE;
      done_d[cpx_fpu_tid] = 1'b1;
    end
    err_d = err_q | (cpx_fpu_vld && slot_q[cpx_fpu_tid] != ISSUED);
  end
  always_ff @(posedge rclk) begin
    if (reset) begin
      for (int t = 0; t < NTHR; t++) slot_q[t] <= FREE;
      port_q <= IDLE;
      ptr_q <= '0;
      tid_q <= '0;
      rq_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      port_q <= port_d;
      ptr_q <= ptr_d;
      tid_q <= tid_d;
      rq_q <= rq_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge rclk) data_q <= data_d;
  assign thr_req_rdy = ~thr_busy;
  assign ffu_lsu_fpop_rq_vld = port_q == REQ;
  assign ffu_lsu_data = rq_q;
  assign ffu_lsu_tid = tid_q;
  assign thr_done = done_q;
  assign sched_err = err_q;
endmodule

// File: tb/tb_ffu_fpop_sched.sv
// tb_ffu_fpop_sched: directed stimulus with a queue scoreboard for issued requests and done pulses
module tb_ffu_fpop_sched;
  typedef struct packed {
    logic [1:0]  tid;
    logic [79:0] data;
  } iss_t;
  logic rclk = 0;
  logic reset;
  logic [3:0] thr_req_vld, thr_req_rdy, thr_kill, thr_busy, thr_done;
  logic [319:0] thr_req_data;
  logic ffu_lsu_fpop_rq_vld, cpx_fpu_vld, sched_err, sched_timeout;
  logic [79:0] ffu_lsu_data;
  logic [1:0] ffu_lsu_tid, cpx_fpu_tid;
  logic lsu_ffu_ack = 0;
  logic man_ack = 0;
  logic auto_ack = 0;
  int checks = 0;
  int failures = 0;
  iss_t exp_iss[$];
  int exp_done[$];
  iss_t mon_e;
  int mon_d;
  ffu_fpop_sched #(.TO_CYC(16)) dut (
    .rclk(rclk),
    .reset(reset),
    .thr_req_vld(thr_req_vld),
    .thr_req_data(thr_req_data),
    .thr_req_rdy(thr_req_rdy),
    .thr_kill(thr_kill),
    .ffu_lsu_fpop_rq_vld(ffu_lsu_fpop_rq_vld),
    .ffu_lsu_data(ffu_lsu_data),
    .ffu_lsu_tid(ffu_lsu_tid),
    .lsu_ffu_ack(lsu_ffu_ack),
    .cpx_fpu_vld(cpx_fpu_vld),
    .cpx_fpu_tid(cpx_fpu_tid),
    .thr_busy(thr_busy),
    .thr_done(thr_done),
    .sched_err(sched_err),
    .sched_timeout(sched_timeout)
  );
  always #5 rclk = ~rclk;
  always @(posedge rclk) begin
    #2;
    lsu_ffu_ack = auto_ack ? ffu_lsu_fpop_rq_vld : man_ack;
  end
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge rclk);
    #1;
  endtask
  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask
  task automatic push_iss(input int t, input logic [79:0] d);
    iss_t e;
    e.tid = 2'(t);
    e.data = d;
    exp_iss.push_back(e);
  endtask
  task automatic ret(input int t);
    cpx_fpu_vld = 1;
    cpx_fpu_tid = 2'(t);
    exp_done.push_back(t);
    step();
    cpx_fpu_vld = 0;
  endtask
  always @(negedge rclk) begin
    if (!reset) begin
      if (ffu_lsu_fpop_rq_vld && lsu_ffu_ack) begin
        if (exp_iss.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL iss_unexpected got tid=%0d data=%0h expected none", ffu_lsu_tid, ffu_lsu_data);
        end else begin
          mon_e = exp_iss.pop_front();
          check("iss_tid", 128'(ffu_lsu_tid), 128'(mon_e.tid));
          check("iss_data", 128'(ffu_lsu_data), 128'(mon_e.data));
        end
      end
      for (int t = 0; t < 4; t++) begin
        if (thr_done[t]) begin
          if (exp_done.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected got tid=%0d expected none", t);
          end else begin
            mon_d = exp_done.pop_front();
            check("done_tid", 128'(t), 128'(mon_d));
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    reset = 1;
    thr_req_vld = 0;
    thr_req_data = 0;
    thr_kill = 0;
    cpx_fpu_vld = 0;
    cpx_fpu_tid = 0;
    step_n(2);
    check("rst_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 0);
    check("rst_data", 128'(ffu_lsu_data), 0);
    check("rst_tid", 128'(ffu_lsu_tid), 0);
    check("rst_busy", 128'(thr_busy), 0);
    check("rst_rdy", 128'(thr_req_rdy), 128'hF);
    check("rst_done", 128'(thr_done), 0);
    check("rst_err", 128'(sched_err), 0);
    check("rst_to", 128'(sched_timeout), 0);
    reset = 0;
    // single request: cycle 0 accept, REQ from cycle 2, ack cycle 4, return cycle 10
    thr_req_vld = 4'b0001;
    thr_req_data[0 +: 80] = 80'hA5;
    push_iss(0, 80'hA5);
    step();
    thr_req_vld = 0;
    check("t1_c1_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 0);
    check("t1_c1_busy", 128'(thr_busy), 128'h1);
    check("t1_c1_rdy", 128'(thr_req_rdy), 128'hE);
    step();
    check("t1_c2_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 1);
    check("t1_c2_tid", 128'(ffu_lsu_tid), 0);
    check("t1_c2_data", 128'(ffu_lsu_data), 128'hA5);
    step();
    check("t1_c3_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 1);
    step();
    man_ack = 1;
    step();
    man_ack = 0;
    check("t1_c5_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 0);
    check("t1_c5_busy", 128'(thr_busy), 128'h1);
    step_n(5);
    ret(0);
    check("t1_c11_done", 128'(thr_done), 128'h1);
    check("t1_c11_busy", 128'(thr_busy), 0);
    step();
    check("t1_c12_done", 128'(thr_done), 0);
    // fairness from ptr=0
    do_reset();
    auto_ack = 1;
    for (int t = 0; t < 4; t++) begin
      thr_req_data[t*80 +: 80] = 80'h100 + 80'(t);
      push_iss(t, 80'h100 + 80'(t));
    end
    thr_req_vld = 4'hF;
    step();
    thr_req_vld = 0;
    step_n(10);
    check("t2_all_busy", 128'(thr_busy), 128'hF);
    check("t2_all_iss", 128'(exp_iss.size()), 0);
    for (int t = 0; t < 4; t++) ret(t);
    step();
    check("t2_all_free", 128'(thr_busy), 0);
    thr_req_data[0 +: 80] = 80'h200;
    thr_req_data[160 +: 80] = 80'h202;
    push_iss(0, 80'h200);
    push_iss(2, 80'h202);
    thr_req_vld = 4'b0101;
    step();
    thr_req_vld = 0;
    step_n(6);
    ret(0);
    ret(2);
    step();
    auto_ack = 0;
    // kill while pending, then kill while granted
    thr_req_data[80 +: 80] = 80'h311;
    thr_req_vld = 4'b0010;
    step();
    thr_req_vld = 0;
    thr_kill = 4'b0010;
    step();
    thr_kill = 0;
    check("t3_kill_busy", 128'(thr_busy), 0);
    check("t3_kill_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 0);
    step();
    check("t3_kill_rq_vld2", 128'(ffu_lsu_fpop_rq_vld), 0);
    thr_req_data[160 +: 80] = 80'h322;
    thr_req_vld = 4'b0100;
    step();
    thr_req_vld = 0;
    step();
    check("t3_grant_tid", 128'(ffu_lsu_tid), 2);
    thr_kill = 4'b0100;
    step();
    thr_kill = 0;
    check("t3_grant_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 1);
    check("t3_grant_busy", 128'(thr_busy), 128'h4);
    push_iss(2, 80'h322);
    man_ack = 1;
    step();
    man_ack = 0;
    check("t3_issued_busy", 128'(thr_busy), 128'h4);
    step_n(2);
    ret(2);
    check("t3_done", 128'(thr_done), 128'h4);
    check("t3_err", 128'(sched_err), 0);
    // stray return and reset mid-request
    cpx_fpu_vld = 1;
    cpx_fpu_tid = 3;
    step();
    cpx_fpu_vld = 0;
    check("t4_err", 128'(sched_err), 1);
    check("t4_no_done", 128'(thr_done), 0);
    step_n(3);
    check("t4_err_hold", 128'(sched_err), 1);
    thr_req_data[0 +: 80] = 80'h400;
    thr_req_vld = 4'b0001;
    step();
    thr_req_vld = 0;
    step();
    check("t4_req_up", 128'(ffu_lsu_fpop_rq_vld), 1);
    reset = 1;
    step();
    reset = 0;
    check("t4_rst_rq_vld", 128'(ffu_lsu_fpop_rq_vld), 0);
    check("t4_rst_busy", 128'(thr_busy), 0);
    check("t4_rst_err", 128'(sched_err), 0);
    cpx_fpu_vld = 1;
    cpx_fpu_tid = 0;
    step();
    cpx_fpu_vld = 0;
    check("t4_post_rst_err", 128'(sched_err), 1);
    do_reset();
    // return colliding with a new request for the same thread
    auto_ack = 1;
    thr_req_data[160 +: 80] = 80'h500;
    push_iss(2, 80'h500);
    thr_req_vld = 4'b0100;
    step();
    thr_req_vld = 0;
    step_n(4);
    check("t5_issued", 128'(thr_busy), 128'h4);
    cpx_fpu_vld = 1;
    cpx_fpu_tid = 2;
    exp_done.push_back(2);
    thr_req_data[160 +: 80] = 80'h555;
    thr_req_vld = 4'b0100;
    check("t5_rdy_refused", 128'(thr_req_rdy[2]), 0);
    step();
    cpx_fpu_vld = 0;
    check("t5_rdy_next", 128'(thr_req_rdy[2]), 1);
    push_iss(2, 80'h555);
    step();
    thr_req_vld = 0;
    check("t5_accepted", 128'(thr_busy), 128'h4);
    step_n(4);
    ret(2);
    step();
    // watchdog
    thr_req_data[240 +: 80] = 80'h600;
    push_iss(3, 80'h600);
    thr_req_vld = 4'b1000;
    step();
    thr_req_vld = 0;
    step_n(24);
`ifdef FFU_SCHED_TIMEOUT_EN
    check("t6_timeout", 128'(sched_timeout), 1);
    check("t6_busy", 128'(thr_busy), 0);
`else
    check("t6_timeout", 128'(sched_timeout), 0);
    check("t6_busy", 128'(thr_busy), 128'h8);
`endif
    check("t6_err", 128'(sched_err), 0);
    auto_ack = 0;
    do_reset();
    step();
    check("end_iss_empty", 128'(exp_iss.size()), 0);
    check("end_done_empty", 128'(exp_done.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
